instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on its rising edge.
REQ-002 rst  input  1  synchronous active-high reset.
REQ-003 in_valid  input  1  field bundle presented.
REQ-004 in_ready  output  1  encoder accepts bundle this cycle.
REQ-005 in_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6-7 illegal.
REQ-006 in_opcode  input  7  opcode copied to word[6:0].
REQ-007 in_funct3 / in_funct7  input  3 / 7  function fields.
REQ-008 in_rd / in_rs1 / in_rs2  input  5 each  register addresses.
REQ-009 in_imm  input  32  signed byte-offset/immediate, same meaning as the decoder's imm output (U: full value, low 12 bits zero).
REQ-010 flush  input  1  discard buffered words and clear address counter.
REQ-011 out_valid  output  1  word available.
REQ-012 out_ready  input  1  consumer takes word.
REQ-013 out_word  output  32  encoded RV32I instruction.
REQ-014 out_addr  output  10  instruction-memory word address of out_word.
REQ-015 out_err  output  1  word's immediate out of range or illegal format.

Function
REQ-016 Input accepted when in_valid && in_ready; in_ready = !full, independent of out_ready.
REQ-017 Accepted bundle encoded combinationally and pushed into a 2-entry FIFO holding {word, err}.
REQ-018 Latency: accept in cycle N -> out_valid high in cycle N+1 when FIFO was empty.
REQ-019 out_word/out_err show FIFO head; stable while out_valid && !out_ready.
REQ-020 Pop on out_valid && out_ready; push and pop in the same cycle keep count unchanged.
REQ-021 Layouts: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-022 Range check sets err: I/S imm outside -2048..2047; B outside -4096..4094 or imm[0]=1; J outside -1048576..1048574 or imm[0]=1; U imm[11:0]!=0; fmt 6-7 always err, word = 0x00000013.
REQ-023 Erroneous words still emitted with truncated fields; never dropped.
REQ-024 I-format shifts (f3=001/101) place in_funct7 in word[31:25] and in_imm[4:0] in word[24:20]; err if in_imm[31:5]!=0.
REQ-025 Address counter increments by 1 per pop; out_addr = counter value; wraps 1023 -> 0 without error.
REQ-026 flush: FIFO empty, counter 0 next cycle; input accepted in the flush cycle is discarded; flush beats push/pop.

Reset
REQ-027 On rst: FIFO empty, out_valid=0, out_err=0, out_word=0, out_addr=0, in_ready=1 next cycle.
REQ-028 rst mid-operation discards all buffered words; no partial word emitted.

Structure
REQ-029 Format codes and opcode constants live in the shared define file used by the decoder.
REQ-030 One sub-module, instr_fifo2 (2-entry {word,err} FIFO); field packing and range check stay in instr_encoder.

Verification
REQ-031 I fmt op=0x13 f3=0 rd=1 rs1=0 imm=5 -> out_word=0x00500093, err=0, out_addr=0.
REQ-032 S fmt op=0x23 f3=2 rs1=1 rs2=2 imm=8 -> 0x0020A423; B op=0x63 f3=0 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3.
REQ-033 J fmt op=0x6F rd=1 imm=2048 -> 0x001000EF; same with imm=2049 -> err=1.
REQ-034 out_ready=0, three back-to-back pushes -> third blocked (in_ready=0 after two); release -> words in order, out_addr 0,1.
REQ-035 Push 1024 words with out_ready=1 -> out_addr wraps 1023 -> 0; flush mid-stream -> out_valid=0 next cycle, next word at out_addr=0.
REQ-036 I fmt imm=2048 -> err=1, out_word[31:20]=0x800; fmt=7 -> out_word=0x00000013, err=1.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding definitions: format codes, opcode constants and the
// {word, err} record carried through the encoder's output buffer.
package instr_encoder_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // Canonical NOP (addi x0, x0, 0) emitted for illegal formats.
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] word;
  } enc_word_t;

  // True when v is representable as an nbits-wide two's-complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int nbits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i >= nbits - 1) && (v[i] != v[31])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry {word, err} FIFO; flush and reset both empty it, flush wins over
// any simultaneous push or pop.
module instr_fifo2
  import instr_encoder_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  enc_word_t push_data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output enc_word_t head_o
);

  enc_word_t  mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Empty FIFO presents an all-zero head so the output word reads 0 when idle.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs a field bundle into a 32-bit word, flags
// out-of-range immediates, and streams words with their memory word address.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  // Handshake: a bundle transfers on in_valid && in_ready, a word on
  // out_valid && out_ready; ready never depends on the partner's valid.

  enc_word_t         enc_d;
  enc_word_t         head;
  logic              fifo_full, fifo_empty;
  logic              push, pop;
  logic              is_shift;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign is_shift = (in_opcode == OP_IMM) &&
                    ((in_funct3 == F3_SLL) || (in_funct3 == F3_SRX));

  always_comb begin
    enc_d.word = NOP_WORD;
    enc_d.err  = 1'b1;
    case (in_fmt)
      FMT_R: begin
        enc_d.word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_d.err  = 1'b0;
      end
      FMT_I: begin
        if (is_shift) begin
          // Shift-immediates carry funct7 above a 5-bit shift amount.
          enc_d.word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_d.err  = |in_imm[31:5];
        end else begin
          enc_d.word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_d.err  = !fits_signed(in_imm, 12);
        end
      end
      FMT_S: begin
        enc_d.word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_d.err  = !fits_signed(in_imm, 12);
      end
      FMT_B: begin
        enc_d.word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_opcode};
        enc_d.err  = !fits_signed(in_imm, 13) || in_imm[0];
      end
      FMT_U: begin
        enc_d.word = {in_imm[31:12], in_rd, in_opcode};
        enc_d.err  = |in_imm[11:0];
      end
      FMT_J: begin
        enc_d.word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                      in_rd, in_opcode};
        enc_d.err  = !fits_signed(in_imm, 21) || in_imm[0];
      end
      default: begin
        enc_d.word = NOP_WORD;
        enc_d.err  = 1'b1;
      end
    endcase
  end

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready && !flush;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  instr_fifo2 u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (enc_d),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  always_comb begin
    addr_d = addr_q;
    if (flush)    addr_d = '0;
    else if (pop) addr_d = addr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign out_word = head.word;
  assign out_err  = head.err;
  assign out_addr = addr_q;

endmodule
